// File: rtl/al422b_pkg.sv
// Shared definitions for the AL422B frame writer: FSM encoding, default geometry
// and the AL422B depth used to bound the frame size at elaboration.
package al422b_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRST,
    ARM,
    ACTIVE,
    DONE
  } state_t;

  localparam int DEF_IMG_W      = 384;
  localparam int DEF_IMG_H      = 288;
  localparam int DEF_RST_CYCLES = 4;
  localparam int DEF_PIX_W      = 17;
  localparam int AL422B_CAPACITY = 393216;

endpackage

// File: rtl/al422b_pattern_gen.sv
// Test pattern source: (col + row) mod 256 for the pixel at the current position.
// Purely combinational; the writer registers it together with WE.
module al422b_pattern_gen #(
  parameter int COL_W = 9,
  parameter int ROW_W = 9
) (
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  output logic [7:0]       pattern
);

  assign pattern = 8'(col) + 8'(row);

endmodule

// File: rtl/al422b_frame_writer.sv
// AL422B write-side controller: captures one windowed frame from a parallel camera
// stream (or test pattern) per start request; WE/DI follow an accepted pixel by 1 clk.
module al422b_frame_writer
  import al422b_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int PIX_W      = DEF_PIX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pattern_en,
  input  logic             frame_valid,
  input  logic             line_valid,
  input  logic [7:0]       cam_data,
  output logic             fifo_wrst_n,
  output logic             fifo_we_n,
  output logic [7:0]       fifo_di,
  output logic             busy,
  output logic             frame_done,
  output logic [PIX_W-1:0] pix_count,
  output logic             line_err,
  output logic             frame_err
);

  localparam int CW  = $clog2(IMG_W + 1);
  localparam int RW  = $clog2(IMG_H + 1);
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CW-1:0]    W_MAX    = CW'(IMG_W);
  localparam logic [RW-1:0]    H_MAX    = RW'(IMG_H);
  localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  if (IMG_W * IMG_H > AL422B_CAPACITY) begin : g_cap_chk
    $error("frame does not fit in the AL422B");
  end
  if ((2 ** PIX_W) < IMG_W * IMG_H) begin : g_pix_chk
    $error("PIX_W too small for IMG_W*IMG_H");
  end
  if (RST_CYCLES < 1) begin : g_rst_chk
    $error("RST_CYCLES must be at least 1");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    col, col_nxt;
  logic [RW-1:0]    row, row_nxt;
  logic [RCW-1:0]   rst_cnt, rst_cnt_nxt;
  logic             pat_mode, pat_mode_nxt;
  logic             fv_q, lv_q;
  logic             wrst_n_nxt, we_n_nxt, busy_nxt, done_nxt;
  logic             line_err_nxt, frame_err_nxt;
  logic [7:0]       di_nxt, pattern;
  logic [PIX_W-1:0] pix_nxt;
  logic             accept, last_line;

  al422b_pattern_gen #(.COL_W(CW), .ROW_W(RW)) u_pattern (
    .col     (col),
    .row     (row),
    .pattern (pattern)
  );

  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_nxt       = row;
    rst_cnt_nxt   = rst_cnt;
    pat_mode_nxt  = pat_mode;
    wrst_n_nxt    = 1'b1;
    we_n_nxt      = 1'b1;
    di_nxt        = fifo_di;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    pix_nxt       = pix_count;
    line_err_nxt  = line_err;
    frame_err_nxt = frame_err;
    accept        = 1'b0;
    last_line     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = WRST;
          pat_mode_nxt  = pattern_en;
          busy_nxt      = 1'b1;
          pix_nxt       = '0;
          line_err_nxt  = 1'b0;
          frame_err_nxt = 1'b0;
          col_nxt       = '0;
          row_nxt       = '0;
          rst_cnt_nxt   = '0;
          wrst_n_nxt    = 1'b0;
        end
      end
      WRST: begin
        if (rst_cnt == RST_LAST) begin
          state_nxt = ARM;
        end else begin
          wrst_n_nxt  = 1'b0;
          rst_cnt_nxt = rst_cnt + 1'b1;
        end
      end
      ARM: begin
        // Only a fresh rising edge starts capture, so a frame in flight is skipped.
        if (!fv_q && frame_valid) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        accept = frame_valid && line_valid && (col < W_MAX) && (row < H_MAX);
        if (accept) begin
          we_n_nxt = 1'b0;
          di_nxt   = pat_mode ? pattern : cam_data;
          col_nxt  = col + 1'b1;
          if (pix_count != PIX_MAX) pix_nxt = pix_count + 1'b1;
        end
        if (lv_q && !line_valid && (col != '0)) begin
          col_nxt = '0;
          if (row < H_MAX) begin
            row_nxt = row + 1'b1;
            if (col < W_MAX) line_err_nxt = 1'b1;
          end
          last_line = (row_nxt == H_MAX);
        end
        if (last_line || (fv_q && !frame_valid)) begin
          state_nxt     = DONE;
          done_nxt      = 1'b1;
          busy_nxt      = 1'b0;
          frame_err_nxt = (row_nxt < H_MAX);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      rst_cnt     <= '0;
      pat_mode    <= 1'b0;
      fv_q        <= 1'b0;
      lv_q        <= 1'b0;
      fifo_wrst_n <= 1'b1;
      fifo_we_n   <= 1'b1;
      fifo_di     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      pix_count   <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      row         <= row_nxt;
      rst_cnt     <= rst_cnt_nxt;
      pat_mode    <= pat_mode_nxt;
      fv_q        <= frame_valid;
      lv_q        <= line_valid;
      fifo_wrst_n <= wrst_n_nxt;
      fifo_we_n   <= we_n_nxt;
      fifo_di     <= di_nxt;
      busy        <= busy_nxt;
      frame_done  <= done_nxt;
      pix_count   <= pix_nxt;
      line_err    <= line_err_nxt;
      frame_err   <= frame_err_nxt;
    end
  end

endmodule

// File: tb/tb_al422b_frame_writer.sv
// Bench for al422b_frame_writer on a reduced 260x6 window; expected FIFO writes are
// derived from the driven frames and checked cycle by cycle.
module tb_al422b_frame_writer;

  localparam int W = 260;
  localparam int H = 6;
  localparam int PW = 11;

  logic          clk = 1'b0;
  logic          reset, start, pattern_en, frame_valid, line_valid;
  logic [7:0]    cam_data;
  logic          fifo_wrst_n, fifo_we_n, busy, frame_done, line_err, frame_err;
  logic [7:0]    fifo_di;
  logic [PW-1:0] pix_count;

  al422b_frame_writer #(.IMG_W(W), .IMG_H(H), .RST_CYCLES(4), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern_en(pattern_en),
    .frame_valid(frame_valid), .line_valid(line_valid), .cam_data(cam_data),
    .fifo_wrst_n(fifo_wrst_n), .fifo_we_n(fifo_we_n), .fifo_di(fifo_di),
    .busy(busy), .frame_done(frame_done), .pix_count(pix_count),
    .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] dat;
  } wr_t;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   wrst_cnt = 0;
  logic done_fv = 1'b0;
  logic [7:0] last_di = 8'h00;
  wr_t  exp_q[$];
  logic [7:0] wlog[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Compare process: every write must match the next expected pixel and cycle.
  always @(negedge clk) begin
    if (reset) begin
      last_di = 8'h00;
    end else begin
      if (!fifo_we_n) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(fifo_di), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
          chk("write_data", 32'(fifo_di), 32'(e.dat));
        end
        wlog.push_back(fifo_di);
        last_di = fifo_di;
        if (!fifo_wrst_n) chk("we_during_wrst", 32'(fifo_we_n), 32'd1);
      end else begin
        chk("di_hold", 32'(fifo_di), 32'(last_di));
      end
      if (!fifo_wrst_n) wrst_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_fv = frame_valid;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters;
    done_cnt = 0;
    wrst_cnt = 0;
    wlog.delete();
  endtask

  task automatic start_capture(input bit pat);
    clear_counters();
    tick();
    start = 1'b1;
    pattern_en = pat;
    tick();
    start = 1'b0;
    pattern_en = 1'b0;
    repeat (8) tick();
  endtask

  // Drives one frame; when cap is set, records the writes the DUT must make.
  task automatic send_frame(input int nlines, input int len, input int short_row,
                            input int short_len, input bit cap, input bit pat,
                            input int start_row, input bit restart,
                            input int rst_row, input int rst_col);
    tick();
    frame_valid = 1'b1;
    repeat (2) tick();
    for (int r = 0; r < nlines; r++) begin
      int l;
      l = (r == short_row) ? short_len : len;
      for (int c = 0; c < l; c++) begin
        tick();
        if (reset) reset = 1'b0;
        line_valid = 1'b1;
        cam_data   = 8'(c + 3 * r);
        start      = ((r == start_row) || restart) && (c == 0);
        if (r == rst_row && c == rst_col) begin
          reset = 1'b1;
          #1;
          chk("rst_we_n", 32'(fifo_we_n), 32'd1);
          chk("rst_wrst_n", 32'(fifo_wrst_n), 32'd1);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_pix", 32'(pix_count), 32'd0);
          exp_q.delete();
          cap = 1'b0;
        end
        if (cap && r < H && c < W) begin
          wr_t e;
          e.cyc = cyc + 1;
          e.dat = pat ? 8'(r + c) : 8'(c + 3 * r);
          exp_q.push_back(e);
        end
      end
      tick();
      if (reset) reset = 1'b0;
      line_valid = 1'b0;
      start = 1'b0;
      repeat (2) tick();
    end
    tick();
    frame_valid = 1'b0;
    repeat (10) tick();
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 100 && done_cnt < target; i++) tick();
    chk("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic end_checks(input int pix, input bit le, input bit fe);
    chk("pix_count", 32'(pix_count), 32'(pix));
    chk("line_err", 32'(line_err), 32'(le));
    chk("frame_err", 32'(frame_err), 32'(fe));
    chk("busy_after", 32'(busy), 32'd0);
    chk("writes_made", 32'(wlog.size()), 32'(pix));
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    chk("wrst_low_cycles", 32'(wrst_cnt), 32'd4);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pattern_en = 1'b0;
    frame_valid = 1'b0;
    line_valid = 1'b0;
    cam_data = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_wrst_n", 32'(fifo_wrst_n), 32'd1);
    chk("reset_we_n", 32'(fifo_we_n), 32'd1);
    chk("reset_di", 32'(fifo_di), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    chk("reset_pix", 32'(pix_count), 32'd0);
    chk("reset_line_err", 32'(line_err), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);

    // Clean frame
    start_capture(1'b0);
    chk("busy_while_armed", 32'(busy), 32'd1);
    send_frame(H, W, -1, 0, 1'b1, 1'b0, -1, 1'b0, -1, -1);
    wait_done(1);
    end_checks(1560, 1'b0, 1'b0);
    chk("clean_r1c1_literal", 32'(wlog[261]), 32'd4);

    // Oversize frame: DONE before frame_valid falls
    start_capture(1'b0);
    send_frame(8, 270, -1, 0, 1'b1, 1'b0, -1, 1'b0, -1, -1);
    wait_done(1);
    end_checks(1560, 1'b0, 1'b0);
    chk("oversize_done_fv_high", 32'(done_fv), 32'd1);

    // Short line and short frame
    start_capture(1'b0);
    send_frame(5, W, 4, 100, 1'b1, 1'b0, -1, 1'b0, -1, -1);
    wait_done(1);
    end_checks(1140, 1'b1, 1'b1);
    chk("short_done_fv_low", 32'(done_fv), 32'd0);

    // Start during a frame in progress: that frame is skipped
    clear_counters();
    send_frame(3, W, -1, 0, 1'b0, 1'b0, 1, 1'b0, -1, -1);
    chk("midarm_no_write_yet", 32'(wlog.size()), 32'd0);
    chk("midarm_busy", 32'(busy), 32'd1);
    send_frame(H, W, -1, 0, 1'b1, 1'b0, -1, 1'b0, -1, -1);
    wait_done(1);
    end_checks(1560, 1'b0, 1'b0);

    // Test pattern, 4 lines
    start_capture(1'b1);
    send_frame(4, W, -1, 0, 1'b1, 1'b1, -1, 1'b0, -1, -1);
    wait_done(1);
    end_checks(1040, 1'b0, 1'b1);
    chk("pattern_r3c255_literal", 32'(wlog[3 * W + 255]), 32'h02);
    chk("pattern_r0c0_literal", 32'(wlog[0]), 32'h00);

    // Repeated start while busy
    start_capture(1'b0);
    send_frame(H, W, -1, 0, 1'b1, 1'b0, -1, 1'b1, -1, -1);
    repeat (40) tick();
    chk("restart_done_count", 32'(done_cnt), 32'd1);
    end_checks(1560, 1'b0, 1'b0);

    // Reset in the middle of capture
    start_capture(1'b0);
    send_frame(H, W, -1, 0, 1'b1, 1'b0, -1, 1'b0, 2, 50);
    repeat (20) tick();
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    chk("rst_pix_after", 32'(pix_count), 32'd0);
    chk("rst_busy_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
